// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, 1-cycle instruction ROM port, prefetch FIFO and valid/ready to decode.
// Optional saturating stall counter on port stall_cnt when IFETCH_STALL_CNT_EN is defined.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_en,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic [31:0]   instr,
    output logic [31:0]   instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready
`ifdef IFETCH_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    localparam int unsigned   PW       = $clog2(DEPTH);
    localparam logic [PW+1:0] DEPTH_W  = (PW+2)'(DEPTH);
    localparam logic [31:0]   PC_MASK  = 32'hFFFF_FFFC;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
        $error("instr_fetch_unit: DEPTH must be a power of 2 and >= 2");
    end

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          pending_q, pending_d;
    logic [31:0]   pending_pc_q, pending_pc_d;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_pc_q    [DEPTH];
    logic [PW+1:0] occupancy;
    logic          push;
    logic          pop;

    // Credit counts the in-flight read but not a same-cycle pop, so a push never finds it full.
    assign occupancy = {1'b0, count_q} + {{(PW + 1){1'b0}}, pending_q};
    assign imem_en   = !rst && !redirect && (occupancy < DEPTH_W);
    assign imem_addr = fetch_pc_q[AW+1:2];

    // Redirect flushes: returning data and any pop in that cycle are discarded.
    assign push = pending_q && !redirect;
    assign pop  = instr_valid && instr_ready && !redirect;

    assign instr_valid = (count_q != '0);
    assign instr       = mem_instr_q[rd_ptr_q];
    assign instr_pc    = mem_pc_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        pending_d    = pending_q;
        pending_pc_d = pending_pc_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & PC_MASK;
            pending_d  = 1'b0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            pending_d = imem_en;
            if (imem_en) begin
                fetch_pc_d   = fetch_pc_q + 32'd4;
                pending_pc_d = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (PW + 1)'(1);
            end else if (!push && pop) begin
                count_d = count_q - (PW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC & PC_MASK;
            pending_q    <= 1'b0;
            pending_pc_q <= 32'h0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= 32'h0;
                mem_pc_q[i]    <= 32'h0;
            end
        end else if (push) begin
            mem_instr_q[wr_ptr_q] <= imem_rdata;
            mem_pc_q[wr_ptr_q]    <= pending_pc_q;
        end
    end

`ifdef IFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'h0;
        end else if (!instr_valid && !redirect && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        push |-> ({1'b0, count_q} < DEPTH_W))
        else $error("instr_fetch_unit: push into full FIFO");

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a synchronous ROM model (word i = 0x2000_0000 | i).
module tb_instr_fetch_unit;

    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
`ifdef IFETCH_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif
    logic [31:0]   rom_q = 32'h0;
    logic [31:0]   exp_pc;
    logic [31:0]   exp_instr;
    int            passed = 0;
    int            total = 0;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4),
        .AW       (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
`ifdef IFETCH_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (imem_en) rom_q <= 32'h2000_0000 | {24'h0, imem_addr};
    end
    assign imem_rdata = rom_q;

    // Checks the head against exp_pc, then steps exp_pc; consumes n cycles with ready held 1.
    task automatic test_stream(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            exp_instr = 32'h2000_0000 | {24'h0, exp_pc[9:2]};
            total++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== exp_instr)
                $display("FAIL %s[%0d]: got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h",
                         name, k, instr_valid, instr_pc, instr, exp_pc, exp_instr);
            else passed++;
            exp_pc = exp_pc + 32'd4;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_ready = 1'b0;
        redirect = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (instr_valid !== 1'b0 || imem_en !== 1'b0)
            $display("FAIL reset_ctrl: got v=%0b en=%0b want 0 0", instr_valid, imem_en);
        else passed++;
        total++;
        if (instr !== 32'h0 || instr_pc !== 32'h0)
            $display("FAIL reset_data: got instr=%h pc=%h want 0 0", instr, instr_pc);
        else passed++;
    endtask

    task automatic test_startup(input string name);
        rst = 1'b0;
        instr_ready = 1'b1;
        #1;
        total++;
        if (imem_en !== 1'b1 || instr_valid !== 1'b0)
            $display("FAIL %s_c1: got en=%0b v=%0b want 1 0", name, imem_en, instr_valid);
        else passed++;
        @(negedge clk);
        total++;
        if (instr_valid !== 1'b0)
            $display("FAIL %s_c2: got v=%0b want 0", name, instr_valid);
        else passed++;
        @(negedge clk);
        exp_pc = 32'h0;
        test_stream(name, 6);
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (imem_en !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== exp_pc)
            $display("FAIL bp_hold: got en=%0b v=%0b pc=%h want 0 1 %h",
                     imem_en, instr_valid, instr_pc, exp_pc);
        else passed++;
        instr_ready = 1'b1;
        test_stream("bp_resume", 8);
    endtask

    task automatic test_redirect_full();
        instr_ready = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (imem_en !== 1'b0)
            $display("FAIL rf_full: got en=%0b want 0", imem_en);
        else passed++;
        redirect = 1'b1;
        redirect_pc = 32'h43;
        #1;
        total++;
        if (imem_en !== 1'b0)
            $display("FAIL rf_noissue: got en=%0b want 0", imem_en);
        else passed++;
        @(negedge clk);
        redirect = 1'b0;
        instr_ready = 1'b1;
        #1;
        total++;
        if (instr_valid !== 1'b0 || imem_en !== 1'b1)
            $display("FAIL rf_n1: got v=%0b en=%0b want 0 1", instr_valid, imem_en);
        else passed++;
        @(negedge clk);
        total++;
        if (instr_valid !== 1'b0)
            $display("FAIL rf_n2: got v=%0b want 0", instr_valid);
        else passed++;
        @(negedge clk);
        exp_pc = 32'h40;
        test_stream("rf_target", 4);
    endtask

    task automatic test_redirect_pop();
        redirect = 1'b1;
        redirect_pc = 32'h80;
        #1;
        total++;
        if (instr_valid !== 1'b1)
            $display("FAIL rp_pop: got v=%0b want 1", instr_valid);
        else passed++;
        @(negedge clk);
        redirect = 1'b0;
        total++;
        if (instr_valid !== 1'b0)
            $display("FAIL rp_n1: got v=%0b want 0", instr_valid);
        else passed++;
        @(negedge clk);
        total++;
        if (instr_valid !== 1'b0)
            $display("FAIL rp_n2: got v=%0b want 0", instr_valid);
        else passed++;
        @(negedge clk);
        exp_pc = 32'h80;
        test_stream("rp_target", 3);
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        redirect_pc = 32'h200;
        #1;
        total++;
        if (imem_en !== 1'b0)
            $display("FAIL b2b_noissue: got en=%0b want 0", imem_en);
        else passed++;
        @(negedge clk);
        redirect = 1'b0;
        total++;
        if (instr_valid !== 1'b0)
            $display("FAIL b2b_n1: got v=%0b want 0", instr_valid);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        exp_pc = 32'h200;
        test_stream("b2b_target", 3);
    endtask

    task automatic test_mid_reset();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (instr_valid !== 1'b0 || imem_en !== 1'b0 || instr_pc !== 32'h0)
            $display("FAIL mr_async: got v=%0b en=%0b pc=%h want 0 0 0",
                     instr_valid, imem_en, instr_pc);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        test_startup("mr_restart");
    endtask

`ifdef IFETCH_STALL_CNT_EN
    task automatic test_stall_cnt();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (stall_cnt !== 32'h0)
            $display("FAIL sc_reset: got %0d want 0", stall_cnt);
        else passed++;
        rst = 1'b0;
        instr_ready = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (stall_cnt !== 32'd2)
            $display("FAIL sc_startup: got %0d want 2", stall_cnt);
        else passed++;
        redirect = 1'b1;
        redirect_pc = 32'h0;
        @(negedge clk);
        redirect = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (stall_cnt !== 32'd4)
            $display("FAIL sc_redirect: got %0d want 4", stall_cnt);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_startup("start");
        test_backpressure();
        test_redirect_full();
        test_redirect_pop();
        test_back_to_back();
        test_mid_reset();
`ifdef IFETCH_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
